// File: rtl/spi_port_bank.sv
// Register bank loaded from checksummed SPI frames and read by the Z80 as DOS-gated I/O ports.
// The SPI and host strobes are oversampled on clk; host reads themselves are combinational.
module spi_port_bank #(
  parameter int unsigned      REG_AW   = 2,
  parameter int unsigned      NREGS    = 3,
  parameter logic [7:0]       PORT_LO  = 8'hDF,
  parameter logic [3:0]       MAGIC    = 4'b1001,
  parameter logic [NREGS-1:0] ACC_MASK = '0,
  parameter logic [NREGS-1:0] IRQ_MASK = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  input  logic [15:0] addr,
  input  logic        rd_n,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        dos,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        iorqge,
  output logic        irq,
  output logic [7:0]  err_cnt
);

  localparam int unsigned      DW       = REG_AW + 8;
  localparam int unsigned      FRAME_W  = 4 + 2 * DW;
  localparam int unsigned      CW       = $clog2(FRAME_W + 2);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FRAME_W);
  localparam logic [CW-1:0]    CNT_MAX  = '1;
  localparam logic [REG_AW:0]  NREGS_W  = (REG_AW + 1)'(NREGS);

  // SPI synchronisers; ss resets low so a frame already in flight at reset never arms
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;
  logic       sck_rise, ss_fall, ss_rise, ss_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign ss_low   = ~ss_q[1];

  logic [FRAME_W-1:0] shift_q;
  logic [CW-1:0]      cnt_q;
  logic               armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (ss_fall) begin
        shift_q <= '0;
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else if (sck_rise && ss_low) begin
        shift_q <= {shift_q[FRAME_W-2:0], mosi_q[1]};
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end
      if (ss_rise) armed_q <= 1'b0;
    end
  end

  logic [3:0]        f_hdr;
  logic [DW-1:0]     f_chk, f_pay;
  logic [REG_AW-1:0] f_idx;
  logic [7:0]        f_data;
  logic              frame_end, frame_ok, err_inc;

  assign f_hdr     = shift_q[FRAME_W-1 -: 4];
  assign f_chk     = shift_q[DW +: DW];
  assign f_pay     = shift_q[DW-1:0];
  assign f_idx     = f_pay[DW-1:8];
  assign f_data    = f_pay[7:0];
  assign frame_end = ss_rise & armed_q;
  assign frame_ok  = (cnt_q == CNT_FULL) && (f_hdr == MAGIC) && (f_chk == ~f_pay) &&
                     ({1'b0, f_idx} < NREGS_W);

  // Host read strobe and index, synchronised into clk
  logic              sel, hit;
  logic [REG_AW-1:0] idx_h;
  logic [2:0]        hrd_q;
  logic [REG_AW-1:0] ridx1_q, ridx2_q, ridx_cap_q;
  logic              host_rd_s, rd_fall;

  assign sel   = ~iorq_n & m1_n & ~rd_n & dos & (addr[7:0] == PORT_LO);
  assign idx_h = addr[8 +: REG_AW];
  assign hit   = sel & ({1'b0, idx_h} < NREGS_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hrd_q      <= '0;
      ridx1_q    <= '0;
      ridx2_q    <= '0;
      ridx_cap_q <= '0;
    end else begin
      hrd_q   <= {hrd_q[1:0], sel};
      ridx1_q <= idx_h;
      ridx2_q <= ridx1_q;
      if (hrd_q[1]) ridx_cap_q <= ridx2_q;
    end
  end

  assign host_rd_s = hrd_q[1];
  assign rd_fall   = ~hrd_q[1] & hrd_q[2];

  // One-deep pending slot; commits are held off while the host is reading
  logic              pend_q;
  logic [REG_AW-1:0] pend_idx_q;
  logic [7:0]        pend_data_q;
  logic              commit;

  assign commit  = pend_q & ~host_rd_s;
  assign err_inc = frame_end & (~frame_ok | pend_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      err_cnt     <= '0;
    end else begin
      if (frame_end && frame_ok && !pend_q) begin
        pend_q      <= 1'b1;
        pend_idx_q  <= f_idx;
        pend_data_q <= f_data;
      end else if (commit) begin
        pend_q <= 1'b0;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];
  logic       irq_d;

  // Clear-on-read is applied first so a same-cycle accumulate lands on zero
  always_comb begin
    regs_d = regs_q;
    irq_d  = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rd_fall && ridx_cap_q == i[REG_AW-1:0] && ACC_MASK[i]) regs_d[i] = 8'h00;
      if (commit && pend_idx_q == i[REG_AW-1:0]) begin
        regs_d[i] = ACC_MASK[i] ? regs_d[i] + pend_data_q : pend_data_q;
        if (IRQ_MASK[i]) irq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      irq <= 1'b0;
    end else begin
      regs_q <= regs_d;
      irq    <= irq_d;
    end
  end

  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'hFF;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (idx_h == i[REG_AW-1:0]) rd_data = regs_q[i];
    end
  end

  assign d_oe   = hit;
  assign iorqge = hit;
  assign d_out  = hit ? rd_data : 8'hFF;

  logic unused_addr;
  assign unused_addr = ^addr[15:8+REG_AW];

endmodule

// File: tb/tb_spi_port_bank.sv
// Scoreboard bench for spi_port_bank: stimulus queues expectations, a monitor compares on probe.
module tb_spi_port_bank;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rd_n = 1'b1, iorq_n = 1'b1, m1_n = 1'b1, dos = 1'b1;
  logic [7:0]  d_out, err_cnt;
  logic        d_oe, iorqge, irq;

  spi_port_bank #(
    .ACC_MASK (3'b001),
    .IRQ_MASK (3'b100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .addr    (addr),
    .rd_n    (rd_n),
    .iorq_n  (iorq_n),
    .m1_n    (m1_n),
    .dos     (dos),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .iorqge  (iorqge),
    .irq     (irq),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // kind 0: {d_oe, iorqge, d_out}; 1: err_cnt; 2: irq pulse count; 3: over-long irq seen
  typedef struct {
    int         kind;
    logic [9:0] exp;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         total = 0, bad = 0, irq_cnt = 0;
  logic       chk_stb = 1'b0, drain_stb = 1'b0;
  logic       irq_prev = 1'b0, irq_long = 1'b0;
  exp_t       mon_e;
  logic [9:0] mon_act;

  always @(negedge clk) begin
    if (irq) irq_cnt <= irq_cnt + 1;
    if (irq && irq_prev) irq_long <= 1'b1;
    irq_prev <= irq;
    if (chk_stb) begin
      total <= total + 1;
      if (sb.size() == 0) begin
        bad <= bad + 1;
        $display("FAIL sb_underflow: probe with no queued expectation");
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          0:       mon_act = {d_oe, iorqge, d_out};
          1:       mon_act = {2'b00, err_cnt};
          2:       mon_act = irq_cnt[9:0];
          default: mon_act = {9'd0, irq_long};
        endcase
        if (mon_act !== mon_e.exp) begin
          bad <= bad + 1;
          $display("FAIL %s: actual=%h required=%h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
    if (drain_stb) begin
      total <= total + 1;
      if (sb.size() != 0) begin
        bad <= bad + 1;
        $display("FAIL sb_drain: actual=%0d required=0 leftover expectations", sb.size());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_val(input int kind, input logic [9:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #2 chk_stb = 1'b1;
    @(posedge clk);
    #2 chk_stb = 1'b0;
  endtask

  function automatic logic [23:0] mk(input logic [3:0] h, input logic [1:0] idx,
                                     input logic [7:0] d);
    return {h, ~{idx, d}, idx, d};
  endfunction

  task automatic spi_shift(input logic [23:0] f, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      mosi = f[23-i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [23:0] f, input int n);
    ss_n = 1'b0;
    #40;
    spi_shift(f, 0, n);
    #40 ss_n = 1'b1;
    #80;
    tick(10);
  endtask

  task automatic host_begin(input logic [15:0] a);
    addr   = a;
    m1_n   = 1'b1;
    iorq_n = 1'b0;
    rd_n   = 1'b0;
  endtask

  task automatic host_end();
    rd_n   = 1'b1;
    iorq_n = 1'b1;
    tick(8);
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [9:0] v, input string name);
    host_begin(a);
    tick(1);
    expect_val(0, v, name);
    host_end();
  endtask

  initial begin
    tick(3);
    #2 rst_n = 1'b1;
    tick(3);
    expect_val(1, 10'h000, "reset_err");
    expect_val(2, 10'h000, "reset_irq");
    read_chk(16'h01DF, 10'h300, "reset_reg1");

    // idx1 data 09: {9, ~109 = 2F6, 109}
    send_frame(24'h9BD909, 24);
    read_chk(16'h01DF, 10'h309, "load_reg1");
    expect_val(1, 10'h000, "load_err");

    send_frame(24'h9BD908, 24);
    expect_val(1, 10'h001, "badchk_err");
    read_chk(16'h01DF, 10'h309, "badchk_reg1");
    send_frame(mk(4'h9, 2'd1, 8'h55), 23);
    expect_val(1, 10'h002, "short_err");
    send_frame(mk(4'h9, 2'd3, 8'h00), 24);
    expect_val(1, 10'h003, "oob_idx_err");
    send_frame(mk(4'hA, 2'd1, 8'h66), 24);
    expect_val(1, 10'h004, "badhdr_err");
    read_chk(16'h01DF, 10'h309, "rejects_reg1");

    // reg0 accumulates: 05 + FE = 03, then clears on read
    send_frame(mk(4'h9, 2'd0, 8'h05), 24);
    send_frame(mk(4'h9, 2'd0, 8'hFE), 24);
    read_chk(16'h00DF, 10'h303, "acc_sum");
    read_chk(16'h00DF, 10'h300, "acc_cleared");

    // Commit deferred across a long read; clear then add leaves the payload
    host_begin(16'h00DF);
    tick(4);
    expect_val(0, 10'h300, "defer_before");
    send_frame(mk(4'h9, 2'd0, 8'h44), 24);
    expect_val(0, 10'h300, "defer_hold");
    host_end();
    read_chk(16'h00DF, 10'h344, "defer_commit");

    // Second frame while the slot is full is dropped
    host_begin(16'h01DF);
    tick(4);
    send_frame(mk(4'h9, 2'd1, 8'h21), 24);
    send_frame(mk(4'h9, 2'd1, 8'h33), 24);
    expect_val(1, 10'h005, "ovf_err");
    expect_val(0, 10'h309, "ovf_hold");
    host_end();
    read_chk(16'h01DF, 10'h321, "ovf_first");
    tick(10);
    read_chk(16'h01DF, 10'h321, "ovf_no_second");

    expect_val(2, 10'h000, "irq_none_yet");
    send_frame(mk(4'h9, 2'd2, 8'h7E), 24);
    expect_val(2, 10'h001, "irq_idx2");
    read_chk(16'h02DF, 10'h37E, "reg2");
    send_frame(mk(4'h9, 2'd1, 8'h10), 24);
    expect_val(2, 10'h001, "irq_idx1_none");
    expect_val(3, 10'h000, "irq_width");
    read_chk(16'h01DF, 10'h310, "reg1_reload");
    read_chk(16'h03DF, 10'h0FF, "unimpl_idx");
    dos = 1'b0;
    read_chk(16'h01DF, 10'h0FF, "dos_gate");
    dos = 1'b1;
    read_chk(16'h01FE, 10'h0FF, "wrong_port");
    expect_val(1, 10'h005, "err_final");

    // Reset in the middle of a frame: the tail must not count as an error
    ss_n = 1'b0;
    #40;
    spi_shift(mk(4'h9, 2'd1, 8'h5A), 0, 12);
    rst_n = 1'b0;
    tick(2);
    #2 rst_n = 1'b1;
    tick(2);
    spi_shift(mk(4'h9, 2'd1, 8'h5A), 12, 12);
    #40 ss_n = 1'b1;
    #80;
    tick(10);
    expect_val(1, 10'h000, "rst_mid_err");
    read_chk(16'h01DF, 10'h300, "rst_mid_reg1");
    send_frame(mk(4'h9, 2'd1, 8'h5A), 24);
    read_chk(16'h01DF, 10'h35A, "post_rst_load");

    @(posedge clk);
    #2 drain_stb = 1'b1;
    @(posedge clk);
    #2 drain_stb = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_port_bank.md
Name: spi_port_bank

Overview:
- Clocked, parametrised successor of the SPI-fed Kempston mouse port block.
- An external controller writes checksummed frames over SPI into a bank of NREGS 8-bit registers. The Z80 reads these registers as DOS-gated I/O ports.
- New relative to the previous generation:
  - oversampled (clocked) SPI front end;
  - configurable register count;
  - per-register accumulate mode for mouse deltas, with clear-on-read;
  - commit deferral during host reads;
  - error counting;
  - an interrupt strobe.

Parameters:
- REG_AW, 2, register-index width; NREGS ≤ 2^REG_AW.
- NREGS, 3, number of implemented registers.
- PORT_LO, 8'hDF, low address byte decoded for host reads.
- MAGIC, 4'b1001, frame header nibble.
- ACC_MASK, 3'b000 (NREGS bits), bit i=1: register i accumulates payload instead of loading it.
- IRQ_MASK, 3'b000 (NREGS bits), bit i=1: a commit to register i pulses irq.

Ports:
- clk  in  1  system clock; at least 4× the SPI sck frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous to clk.
- ss_n  in  1  SPI select, active low, asynchronous.
- mosi  in  1  SPI data, MSB first.
- addr  in  16  Z80 address bus.
- rd_n  in  1  Z80 read strobe.
- iorq_n  in  1  Z80 I/O request.
- m1_n  in  1  Z80 M1.
- dos  in  1  DOS-gate enable; high permits decode.
- d_out  out  8  read data.
- d_oe  out  1  data bus drive enable.
- iorqge  out  1  high while this block claims a read cycle.
- irq  out  1  one-clk strobe on a masked commit.
- err_cnt  out  8  saturating count of rejected frames.

Behaviour:
- Reset: all registers 0, err_cnt=0, irq=0, pending slot empty, shifter cleared.
- **SPI front end**
  - sck, ss_n and mosi each pass through a 2-FF synchroniser.
  - A synchronised sck rising edge while ss_n=0 shifts mosi into the shift register (MSB first) and increments the bit counter.
  - Synchronised ss_n falling edge clears the shift register and bit counter.
- **Frame format**, FRAME_W = 4 + 2·(REG_AW+8) bits, 24 by default:
  - header = MAGIC (4 bits);
  - check = bitwise complement of {idx, data};
  - then idx (REG_AW bits) and data (8 bits).
- **Frame end** (synchronised ss_n rising edge): the frame is valid only if all of the following hold:
  - bit count = FRAME_W exactly;
  - header = MAGIC;
  - check = ~{idx, data};
  - idx < NREGS.
- Valid frame → loaded into the 1-deep pending slot. Invalid frame → err_cnt+1, saturating at 255.
- **Commit**, on the first clk where pending is full and host_rd_s=0:
  - ACC_MASK[idx]=0: reg[idx] ← data.
  - ACC_MASK[idx]=1: reg[idx] ← reg[idx]+data, 8-bit wrap; data is two's-complement.
  - irq=1 for exactly that clk if IRQ_MASK[idx]=1.
  - Pending slot is emptied.
- **Deferral and overflow**
  - While host_rd_s=1, the commit waits.
  - A valid frame that ends while the pending slot is still full is dropped and increments err_cnt.
- **Host decode** (combinational, asynchronous to clk):
  - sel = ~iorq_n & m1_n & ~rd_n & dos & (addr[7:0]==PORT_LO).
  - idx_h = addr[8+REG_AW-1:8].
  - idx_h < NREGS: d_oe=1, iorqge=1, d_out=reg[idx_h].
  - idx_h ≥ NREGS: d_oe=0, iorqge=0, d_out=8'hFF.
  - No sel: d_oe=0, iorqge=0, d_out=8'hFF.
- **Clear-on-read**
  - host_rd_s is sel passed through a 2-FF synchroniser; idx_h is captured alongside it.
  - On the host_rd_s falling edge, if ACC_MASK[captured idx]=1, that register clears to 0.
  - If a commit to the same register fires in the same clk, the result is data, i.e. clear happens before the add.
- **Reset mid-frame**: asserting rst_n low mid-frame discards the partial frame; no err_cnt increment.

Test Plan:
- Default parameters; send frame 0x9_F6_09 (idx=1, data=0x09) -> after ss_n rises plus ≤4 clk, a read of port 0x01DF returns 0x09 with d_oe=1 and iorqge=1; err_cnt=0.
- Send 0x9_F6_08 -> reg1 unchanged; err_cnt=1. Send a valid 23-bit frame -> err_cnt=2. Send idx=3 with a correct check -> rejected; err_cnt=3.
- ACC_MASK=3'b001; send idx0 frames with data 0x05 then 0xFE -> reg0=0x03. Host read of 0x00DF returns 0x03; after the read ends, reg0=0x00.
- Hold a host read of 0x00DF and end a valid frame (idx0, data 0x44) during it -> d_out stays constant until rd_n rises; reg0=0x44 within 4 clk after.
- While pending is held by a long host read, complete two valid frames -> first commits after the read; second dropped; err_cnt+1.
- IRQ_MASK=3'b100; frame to idx2 -> single one-clk irq pulse. Frame to idx1 -> no pulse. Read 0x03DF -> d_oe=0.
